// File: rtl/dlx_pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage DLX pipeline: stage enables, bubbles,
// wrong-path squash and EX operand forwarding, tracked through private EX/MEM shadows.
module dlx_pipe_ctrl #(
  parameter int unsigned BRANCH_PENALTY = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_load,
  input  logic             id_store,
  input  logic             ex_branch_taken,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             pipe_en,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       ctl_status,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned FlushW = 3;

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StLoadStall = 2'd1,
    StMemWait   = 2'd2,
    StFlush     = 2'd3
  } status_e;

  localparam logic [1:0] FwdRf  = 2'b00;
  localparam logic [1:0] FwdEx  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  logic              ex_v_q, ex_ld_q, ex_st_q;
  logic [4:0]        ex_rd_q;
  logic              mem_v_q, mem_ld_q, mem_st_q;
  logic [4:0]        mem_rd_q;
  logic [FlushW-1:0] flush_cnt_q;
  logic [1:0]        fwd_a_q, fwd_b_q;
  logic [1:0]        fwd_a_d, fwd_b_d;
  logic [CNT_W-1:0]  stall_q;

  logic mem_stall, take, kill, load_use, ex_rd_hit;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  status_e status;

  assign mem_stall = mem_v_q & (mem_ld_q | mem_st_q) & ~dmem_ready;
  assign take      = ~mem_stall & ex_v_q & ex_branch_taken;
  assign kill      = flush_cnt_q != '0;
  assign ex_rd_hit = (ex_rd_q == id_rs1) | (id_rs2_used & (ex_rd_q == id_rs2));
  assign load_use  = ~mem_stall & ~take & ~kill & id_valid & ex_v_q & ex_ld_q &
                     (ex_rd_q != 5'd0) & ex_rd_hit;

  // Outputs are forced to a safe idle pattern while reset is held.
  assign pipe_en     = reset_n & ~mem_stall;
  assign pc_en       = reset_n & ~mem_stall & ~load_use;
  assign ifid_en     = pc_en;
  assign idex_bubble = ~reset_n | ~id_valid | take | kill | load_use;

  always_comb begin
    status = StRun;
    if (!reset_n)          status = StRun;
    else if (mem_stall)    status = StMemWait;
    else if (take || kill) status = StFlush;
    else if (load_use)     status = StLoadStall;
  end
  assign ctl_status = status;

  // EX/MEM producers seen by the instruction about to enter EX; loads in EX cannot forward.
  assign ex_hit_a  = ex_v_q & ~ex_ld_q & (ex_rd_q != 5'd0) & (ex_rd_q == id_rs1);
  assign ex_hit_b  = ex_v_q & ~ex_ld_q & (ex_rd_q != 5'd0) & (ex_rd_q == id_rs2);
  assign mem_hit_a = mem_v_q & ~mem_st_q & (mem_rd_q != 5'd0) & (mem_rd_q == id_rs1);
  assign mem_hit_b = mem_v_q & ~mem_st_q & (mem_rd_q != 5'd0) & (mem_rd_q == id_rs2);

  always_comb begin
    fwd_a_d = FwdRf;
    fwd_b_d = FwdRf;
    if (!idex_bubble) begin
      if (ex_hit_a)       fwd_a_d = FwdEx;
      else if (mem_hit_a) fwd_a_d = FwdMem;
      if (id_rs2_used) begin
        if (ex_hit_b)       fwd_b_d = FwdEx;
        else if (mem_hit_b) fwd_b_d = FwdMem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_v_q      <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_st_q     <= 1'b0;
      ex_rd_q     <= 5'd0;
      mem_v_q     <= 1'b0;
      mem_ld_q    <= 1'b0;
      mem_st_q    <= 1'b0;
      mem_rd_q    <= 5'd0;
      flush_cnt_q <= '0;
      fwd_a_q     <= FwdRf;
      fwd_b_q     <= FwdRf;
    end else if (pipe_en) begin
      mem_v_q  <= ex_v_q;
      mem_ld_q <= ex_ld_q;
      mem_st_q <= ex_st_q;
      mem_rd_q <= ex_rd_q;
      ex_v_q   <= ~idex_bubble;
      ex_ld_q  <= id_load;
      ex_st_q  <= id_store;
      ex_rd_q  <= id_rd;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      if (take)      flush_cnt_q <= FlushW'(BRANCH_PENALTY);
      else if (kill) flush_cnt_q <= flush_cnt_q - FlushW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (!pc_en && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign fwd_a        = fwd_a_q;
  assign fwd_b        = fwd_b_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_dlx_pipe_ctrl.sv
// Randomized bench for dlx_pipe_ctrl: an instruction-level model of the in-flight EX/MEM
// instructions predicts every output each cycle, plus directed hazard scenarios.
module tb_dlx_pipe_ctrl;

  localparam int unsigned BP = 1;
  localparam int unsigned CW = 4;
  localparam int unsigned CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          id_rs2_used = 1'b0, id_load = 1'b0, id_store = 1'b0;
  logic          ex_branch_taken = 1'b0, dmem_ready = 1'b1;
  logic          pc_en, ifid_en, pipe_en, idex_bubble;
  logic [1:0]    fwd_a, fwd_b, ctl_status;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  dlx_pipe_ctrl #(.BRANCH_PENALTY(BP), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_load(id_load), .id_store(id_store),
    .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready), .pc_en(pc_en),
    .ifid_en(ifid_en), .pipe_en(pipe_en), .idex_bubble(idex_bubble), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .ctl_status(ctl_status), .stall_cycles(stall_cycles)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Model: the instructions that are in EX (slot 0) and MEM (slot 1).
  typedef struct {bit v; bit [4:0] rd; bit ld; bit st;} instr_t;
  instr_t inflight[2];
  int     squash_left = 0;
  int     m_fwd_a = 0, m_fwd_b = 0, m_stalls = 0;
  bit     e_pipe, e_pc, e_bub, redirect, squashing;
  int     e_stat;

  // Nearest older producer of s that can supply its result to EX.
  function automatic int src_for(input bit [4:0] s);
    for (int k = 0; k < 2; k++) begin
      if (inflight[k].v && inflight[k].rd != 0 && inflight[k].rd == s) begin
        if (k == 0 && !inflight[k].ld) return 1;
        if (k == 1 && !inflight[k].st) return 2;
      end
    end
    return 0;
  endfunction

  task automatic model_eval();
    bit mem_busy, hazard;
    mem_busy  = inflight[1].v && (inflight[1].ld || inflight[1].st) && !dmem_ready;
    redirect  = !mem_busy && inflight[0].v && ex_branch_taken;
    squashing = squash_left > 0;
    hazard    = !mem_busy && !redirect && !squashing && id_valid && inflight[0].v &&
                inflight[0].ld && inflight[0].rd != 0 &&
                (inflight[0].rd == id_rs1 || (id_rs2_used && inflight[0].rd == id_rs2));
    if (!reset_n) begin
      e_pipe = 0; e_pc = 0; e_bub = 1; e_stat = 0;
    end else begin
      e_pipe = !mem_busy;
      e_pc   = !mem_busy && !hazard;
      e_bub  = !id_valid || redirect || squashing || hazard;
      e_stat = mem_busy ? 2 : (redirect || squashing) ? 3 : hazard ? 1 : 0;
    end
  endtask

  task automatic model_update();
    if (!reset_n) begin
      inflight[0] = '{0, 0, 0, 0};
      inflight[1] = '{0, 0, 0, 0};
      squash_left = 0; m_fwd_a = 0; m_fwd_b = 0; m_stalls = 0;
      return;
    end
    if (!e_pc && m_stalls < CntMax) m_stalls++;
    if (e_pipe) begin
      m_fwd_a = e_bub ? 0 : src_for(id_rs1);
      m_fwd_b = (e_bub || !id_rs2_used) ? 0 : src_for(id_rs2);
      inflight[1] = inflight[0];
      inflight[0] = '{!e_bub, id_rd, id_load, id_store};
      if (redirect) squash_left = BP;
      else if (squashing) squash_left--;
    end
  endtask

  task automatic drive(input bit rst_n, input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit used, input bit [4:0] rd, input bit ld, input bit st,
                       input bit tk, input bit rdy);
    @(negedge clk);
    reset_n = rst_n; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs2_used = used;
    id_rd = rd; id_load = ld; id_store = st; ex_branch_taken = tk; dmem_ready = rdy;
    #2;
    model_eval();
    check("pc_en", pc_en, e_pc);
    check("ifid_en", ifid_en, e_pc);
    check("pipe_en", pipe_en, e_pipe);
    check("idex_bubble", idex_bubble, e_bub);
    check("ctl_status", ctl_status, e_stat);
    check("fwd_a", fwd_a, m_fwd_a);
    check("fwd_b", fwd_b, m_fwd_b);
    check("stall_cycles", stall_cycles, m_stalls);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
  endtask

  task automatic nop_cycle();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
  endtask

  initial begin
    inflight[0] = '{0, 0, 0, 0};
    inflight[1] = '{0, 0, 0, 0};
    do_reset();
    check("rst_fwd_a", fwd_a, 0);
    check("rst_stall", stall_cycles, 0);

    // Load-use: LW r3 then ADD r4,r3,r5.
    drive(1, 1, 0, 0, 0, 3, 1, 0, 0, 1); tick();
    drive(1, 1, 3, 5, 1, 4, 0, 0, 0, 1);
    check("lu_pc_en", pc_en, 0);
    check("lu_bubble", idex_bubble, 1);
    check("lu_status", ctl_status, 1);
    tick();
    drive(1, 1, 3, 5, 1, 4, 0, 0, 0, 1);
    check("lu_release", pc_en, 1);
    tick();
    check("lu_fwd_a", fwd_a, 2);
    check("lu_stalls", stall_cycles, 1);

    // Back-to-back ALU, then a producer writing r0.
    drive(1, 1, 0, 0, 0, 1, 0, 0, 0, 1); tick();
    drive(1, 1, 1, 1, 1, 2, 0, 0, 0, 1); tick();
    check("alu_fwd_a", fwd_a, 1);
    check("alu_fwd_b", fwd_b, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    drive(1, 1, 0, 0, 1, 6, 0, 0, 0, 1); tick();
    check("r0_fwd_a", fwd_a, 0);
    check("r0_fwd_b", fwd_b, 0);

    // Taken branch: resolve cycle plus BP squash cycles.
    nop_cycle();
    drive(1, 1, 2, 0, 0, 7, 0, 0, 1, 1);
    check("br_bubble0", idex_bubble, 1);
    check("br_status0", ctl_status, 3);
    check("br_pc0", pc_en, 1);
    tick();
    drive(1, 1, 2, 0, 0, 7, 0, 0, 0, 1);
    check("br_bubble1", idex_bubble, 1);
    check("br_status1", ctl_status, 3);
    tick();
    drive(1, 1, 2, 0, 0, 7, 0, 0, 0, 1);
    check("br_done", ctl_status, 0);
    check("br_pass", idex_bubble, 0);
    tick();

    // Memory wait on a store for 3 cycles.
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 0, 1, 0, 1); tick();
    nop_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("mw_pipe_en", pipe_en, 0);
      check("mw_status", ctl_status, 2);
      tick();
    end
    check("mw_stalls", stall_cycles, 3);

    // Branch in EX while MEM waits: take is deferred.
    drive(1, 1, 0, 0, 0, 0, 0, 1, 0, 1); tick();
    nop_cycle();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    check("bd_status", ctl_status, 2);
    tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    check("bd_take", ctl_status, 3);
    tick();

    // Reset while flush_cnt is 1.
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rf_status", ctl_status, 0);
    tick();
    drive(1, 1, 4, 0, 0, 5, 0, 0, 0, 1);
    check("rf_bubble", idex_bubble, 0);
    check("rf_status2", ctl_status, 0);
    check("rf_stall", stall_cycles, 0);
    tick();

    // Randomized traffic on a small register set to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      int kind;
      kind = $urandom_range(0, 7);
      drive($urandom_range(0, 199) != 0, $urandom_range(0, 4) != 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), kind < 2, kind == 2, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
